fifo_uart_tx: RTL and testbench

Serial transmitter that drains the 8-bit synchronous FIFO from its read side. It pops one byte at a time whenever the FIFO is non-empty and transmission is enabled. Each byte goes out as an 8N1 asynchronous serial frame: one start bit, 8 data bits LSB first, one stop bit. It sits between the FIFO's `read`/`dout`/`fifo_empty` ports and the chip-level serial pin.

---
 rtl/fifo_uart_tx.sv | 183 ++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//
// Drains an 8-bit synchronous FIFO from its read side and sends each byte as
// an 8N1 serial frame: one start bit (0), eight data bits LSB first, and one
// stop bit (1). Each bit lasts CLKS_PER_BIT clock cycles.
//
// Sequence per byte: FETCH pops the FIFO, LOAD captures the read data, then
// START / DATA x8 / STOP drive the line. When the FIFO still holds data and
// transmission is enabled at the end of STOP, the next FETCH follows directly,
// so back-to-back frames start every 10*CLKS_PER_BIT + 2 cycles.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit, 2..65535
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   enable      in   allows new frames to start (sampled in IDLE and in the
//                    last STOP cycle only)
//   fifo_empty  in   FIFO empty flag
//   fifo_dout   in   FIFO read data, valid the cycle after fifo_read
//   fifo_read   out  one-cycle pop strobe to the FIFO
//   tx          out  serial line, idles high, registered
//   busy        out  high whenever a frame is in progress (state != IDLE)
//   frame_done  out  one-cycle pulse in the last cycle of the stop bit
//   sent_count  out  completed frame count, wraps 255 -> 0
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_read,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] sent_count
);

  // Baud counter is just wide enough to hold 0..CLKS_PER_BIT-1.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_PRE_LAST = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] baud_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shreg_reg;
  logic          tx_reg;
  logic          fifo_read_reg;
  logic          busy_reg;
  logic          frame_done_reg;
  logic [7:0]    sent_count_reg;

  logic baud_last;
  logic launch;

  assign baud_last = (baud_reg == BAUD_LAST);
  // A new frame may only begin when there is something to pop; this is the
  // sole path into FETCH, so the FIFO can never be read while empty.
  assign launch    = enable & ~fifo_empty;

  // All outputs are registered: each one is set on the edge that enters the
  // state in which it must be visible, so it lines up exactly with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      baud_reg       <= '0;
      bit_idx_reg    <= 3'd0;
      shreg_reg      <= 8'h00;
      tx_reg         <= 1'b1;
      fifo_read_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      sent_count_reg <= 8'h00;
    end else begin
      // Strobes default low; they are raised for exactly one cycle below.
      fifo_read_reg  <= 1'b0;
      frame_done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (launch) begin
            state_reg     <= FETCH;
            fifo_read_reg <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end

        FETCH: begin
          // The FIFO registers the pop now; its data appears during LOAD.
          state_reg <= LOAD;
        end

        LOAD: begin
          shreg_reg <= fifo_dout;
          baud_reg  <= '0;
          tx_reg    <= 1'b0;          // start bit begins next cycle
          state_reg <= START;
        end

        START: begin
          if (baud_last) begin
            baud_reg    <= '0;
            bit_idx_reg <= 3'd0;
            tx_reg      <= shreg_reg[0];
            state_reg   <= DATA;
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end

        DATA: begin
          if (baud_last) begin
            baud_reg  <= '0;
            shreg_reg <= {1'b0, shreg_reg[7:1]};
            if (bit_idx_reg == 3'd7) begin
              tx_reg    <= 1'b1;      // stop bit
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              // The register has not shifted yet, so the next bit is [1].
              tx_reg      <= shreg_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end

        STOP: begin
          // Raise the pulse one cycle early so the registered output is high
          // during the final stop cycle. BAUD_PRE_LAST is 0 when
          // CLKS_PER_BIT = 2, which still leaves one cycle of lead.
          if (baud_reg == BAUD_PRE_LAST) begin
            frame_done_reg <= 1'b1;
          end
          if (baud_last) begin
            baud_reg       <= '0;
            sent_count_reg <= sent_count_reg + 8'd1;
            if (launch) begin
              // Refetch directly; the line stays high through FETCH/LOAD.
              state_reg     <= FETCH;
              fifo_read_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end

        default: begin
          // Unused encodings recover to a quiet idle line.
          state_reg <= IDLE;
          baud_reg  <= '0;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_read  = fifo_read_reg;
  assign tx         = tx_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign sent_count = sent_count_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Bench for fifo_uart_tx with CLKS_PER_BIT = 4. Contains a queue-based
// synchronous FIFO feeding the transmitter, a frame-level reference model
// that predicts every output cycle by cycle from the byte being sent and the
// position within the frame, a serial decoder on tx, and directed scenarios:
// reset, single byte, burst, enable gating, asynchronous reset mid-frame and
// sent_count wrap.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int C     = 4;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_read;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [7:0] sent_count;

  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;

  // FIFO contents, plus a shadow copy the model pops on its own schedule
  logic [7:0] fq[$];
  logic [7:0] mq[$];
  int rd_count = 0;
  int fd_count = 0;
  int underflow = 0;

  // Reference model: m_pos = -1 when idle, otherwise cycles since FETCH
  // (0 = FETCH, 1 = LOAD, 2..FRAME+1 = the serial frame itself).
  int         m_pos = -1;
  int         m_count = 0;
  logic [7:0] m_byte = 8'h00;

  // Serial decoder state
  logic       mon_active = 1'b0;
  int         mon_t = 0;
  int         mon_b = 0;
  logic [9:0] mon_bits = '0;
  logic [9:0] mon_last = '0;
  int         mon_frames = 0;
  int         mon_stop_err = 0;
  logic [7:0] mon_bytes[$];
  int         mon_starts[$];

  fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_read  (fifo_read),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc_n, act, exp);
    end
  endtask

  // Expected line level at model position p for byte bv.
  function automatic int exp_tx(input int p, input logic [7:0] bv);
    int k;
    int b;
    if (p < 2 || p >= 2 + FRAME) return 1;
    k = p - 2;
    b = k / C;
    if (b == 0) return 0;
    if (b <= 8) return int'(bv[b-1]);
    return 1;
  endfunction

  // Synchronous FIFO: write and pop take effect on the clock edge; read data
  // is valid the cycle after the pop.
  always @(posedge clk) begin
    cyc_n++;
    fifo_empty <= ((fq.size() + (wr_en ? 1 : 0)
                   - ((fifo_read && fq.size() != 0) ? 1 : 0)) == 0);
    if (frame_done) fd_count++;
    if (fifo_read) begin
      rd_count++;
      if (fq.size() == 0) underflow++;
      else fifo_dout <= fq.pop_front();
    end
    if (wr_en) begin
      fq.push_back(wr_data);
      mq.push_back(wr_data);
    end
  end

  // Frame-level model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos   = -1;
      m_count = 0;
    end else if (m_pos < 0 || m_pos == FRAME + 1) begin
      if (m_pos == FRAME + 1) m_count++;
      if (enable && !fifo_empty && mq.size() > 0) begin
        m_pos  = 0;
        m_byte = mq.pop_front();
      end else begin
        m_pos = -1;
      end
    end else begin
      m_pos++;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("tx",         int'(tx),         exp_tx(m_pos, m_byte));
      check("busy",       int'(busy),       int'(m_pos >= 0));
      check("fifo_read",  int'(fifo_read),  int'(m_pos == 0));
      check("frame_done", int'(frame_done), int'(m_pos == FRAME + 1));
      check("sent_count", int'(sent_count), m_count % 256);
    end
  end

  // Serial decoder: samples mid-bit, records start cycle and byte
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && tx == 1'b0) begin
        mon_active = 1'b1;
        mon_t      = 0;
        mon_bits   = '0;
        mon_starts.push_back(cyc_n);
      end else if (mon_active) begin
        mon_t++;
      end
      if (mon_active && (mon_t % C) == C / 2) begin
        mon_b = mon_t / C;
        mon_bits[mon_b] = tx;
        if (mon_b == 9) begin
          mon_active = 1'b0;
          if (mon_bits[0] != 1'b0 || mon_bits[9] != 1'b1) mon_stop_err++;
          mon_bytes.push_back(mon_bits[8:1]);
          mon_last = mon_bits;
          mon_frames++;
          $display("frame %0d byte 0x%02h start cycle %0d", mon_frames,
                   mon_bits[8:1], mon_starts[mon_starts.size()-1]);
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (mon_frames < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frame_timeout", int'(mon_frames >= n), 1);
  endtask

  task automatic wait_tx_low(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tx !== 1'b0 && k < budget);
    check("start_timeout", int'(tx === 1'b0), 1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_done !== 1'b1 && k < budget);
    check("done_timeout", int'(frame_done === 1'b1), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    int mf0;
    int mb0;
    int ms0;
    int se0;
    int nz;

    // ---- reset state and idle with empty FIFO
    repeat (3) @(negedge clk);
    check("rst_tx",         int'(tx), 1);
    check("rst_busy",       int'(busy), 0);
    check("rst_fifo_read",  int'(fifo_read), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_sent_count", int'(sent_count), 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_reads", rd_count, 0);
    check("idle_tx",    int'(tx), 1);
    check("idle_busy",  int'(busy), 0);

    // ---- single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1
    push_byte(8'hA5);
    wait_frames(1, 200);
    repeat (8) @(negedge clk);
    check("a5_reads",   rd_count, 1);
    check("a5_bits",    int'(mon_last), int'(10'b1101001010));
    check("a5_byte",    int'(mon_bytes[0]), 'hA5);
    check("a5_count",   int'(sent_count), 1);
    check("a5_done",    fd_count, 1);
    check("a5_empty",   int'(fifo_empty), 1);
    check("a5_busy",    int'(busy), 0);

    // ---- burst of 7 bytes 0x11..0x77
    do_reset();
    rd0 = rd_count; mf0 = mon_frames; mb0 = mon_bytes.size(); ms0 = mon_starts.size();
    for (int i = 1; i <= 7; i++) push_byte(8'(i * 17));
    wait_frames(mf0 + 7, 7 * 60);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 7; i++)
      check("burst_byte", int'(mon_bytes[mb0 + i]), 17 * (i + 1));
    for (int i = 0; i < 6; i++)
      check("burst_spacing", mon_starts[ms0 + i + 1] - mon_starts[ms0 + i], 42);
    check("burst_count", int'(sent_count), 7);
    check("burst_reads", rd_count - rd0, 7);
    check("burst_busy",  int'(busy), 0);

    // ---- enable dropped during the first frame's data phase
    rd0 = rd_count; mf0 = mon_frames; mb0 = mon_bytes.size();
    push_byte(8'h3C);
    push_byte(8'hC3);
    push_byte(8'h5A);
    repeat (2 * C) @(negedge clk);
    enable = 1'b0;
    repeat (60) @(negedge clk);
    check("gate_reads",  rd_count - rd0, 1);
    check("gate_frames", mon_frames - mf0, 1);
    check("gate_left",   fq.size(), 2);
    check("gate_busy",   int'(busy), 0);
    check("gate_byte0",  int'(mon_bytes[mb0]), 'h3C);
    enable = 1'b1;
    wait_frames(mf0 + 3, 150);
    repeat (8) @(negedge clk);
    check("gate_byte1",  int'(mon_bytes[mb0 + 1]), 'hC3);
    check("gate_byte2",  int'(mon_bytes[mb0 + 2]), 'h5A);
    check("gate_count",  int'(sent_count), 10);

    // ---- asynchronous reset during data bit 3 of 0x05
    enable = 1'b0;
    mf0 = mon_frames; mb0 = mon_bytes.size();
    push_byte(8'h05);
    push_byte(8'h6E);
    enable = 1'b1;
    wait_tx_low(20);
    repeat (17) @(posedge clk);
    #2;
    check("pre_rst_tx", int'(tx), 0);
    rst_n = 1'b0;
    #1;
    check("arst_tx",         int'(tx), 1);
    check("arst_busy",       int'(busy), 0);
    check("arst_fifo_read",  int'(fifo_read), 0);
    check("arst_sent_count", int'(sent_count), 0);
    #1;
    rst_n = 1'b1;
    wait_frames(mf0 + 1, 150);
    repeat (8) @(negedge clk);
    check("arst_next_byte", int'(mon_bytes[mb0]), 'h6E);
    check("arst_count",     int'(sent_count), 1);
    check("arst_fifo_left", fq.size(), 0);

    // ---- 256 frames of 0x00: sent_count wraps to 0 on the last one
    do_reset();
    enable = 1'b0;
    mf0 = mon_frames; mb0 = mon_bytes.size(); se0 = mon_stop_err;
    for (int i = 0; i < 256; i++) push_byte(8'h00);
    enable = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      wait_done(60);
      @(negedge clk);
      check("wrap_count", int'(sent_count), i % 256);
    end
    repeat (8) @(negedge clk);
    nz = 0;
    for (int i = 0; i < 256; i++) if (mon_bytes[mb0 + i] != 8'h00) nz++;
    check("wrap_frames",    mon_frames - mf0, 256);
    check("wrap_nonzero",   nz, 0);
    check("wrap_framing",   mon_stop_err - se0, 0);
    check("wrap_busy",      int'(busy), 0);
    check("underflow",      underflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
